// File: rtl/tdm_demux_1to4_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4_if
//   Bundles the serial TDM input side and the parallel channel output side of
//   tdm_demux_1to4.
//
//   Signals:
//     din        serial data bit
//     din_vld    qualifies din/sync
//     sync       frame marker on the first bit of slot 0
//     dout       4 channels, channel k in dout[k*DATA_W +: DATA_W]
//     dout_vld   per-channel 1-cycle update pulse
//     locked     demux is frame-aligned
//     frame_err  1-cycle alignment error pulse
//     par_err    per-channel parity error pulse (only with TDM_PARITY_EN)
//
//   Modports:
//     master  drives the serial stream, observes the channel outputs
//     slave   the demux itself
//
//   Optional build macro: TDM_PARITY_EN
// -----------------------------------------------------------------------------
interface tdm_demux_1to4_if #(
  parameter int DATA_W = 8
);
  logic                  din;
  logic                  din_vld;
  logic                  sync;
  logic [4*DATA_W-1:0]   dout;
  logic [3:0]            dout_vld;
  logic                  locked;
  logic                  frame_err;
`ifdef TDM_PARITY_EN
  logic [3:0]            par_err;
`endif

  modport master (
    output din, din_vld, sync,
`ifdef TDM_PARITY_EN
    input  par_err,
`endif
    input  dout, dout_vld, locked, frame_err
  );

  modport slave (
    input  din, din_vld, sync,
`ifdef TDM_PARITY_EN
    output par_err,
`endif
    output dout, dout_vld, locked, frame_err
  );
endinterface

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
//   Receive-side 1:4 TDM demultiplexer. Tracks frame alignment on a serial
//   stream (4 slots of DATA_W bits, MSB first, sync on the first bit of
//   slot 0), deserialises each slot onto its channel and flags alignment
//   errors.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   tdm_demux_1to4_if.slave (din, din_vld, sync in;
//           dout, dout_vld, locked, frame_err [, par_err] out)
//
//   Optional build macro: TDM_PARITY_EN
//     Each slot carries one extra even-parity bit after the payload; slot
//     completion happens on that bit and par_err[k] pulses with dout_vld[k]
//     when the parity does not check.
// -----------------------------------------------------------------------------
module tdm_demux_1to4 #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  tdm_demux_1to4_if.slave         bus
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_W  = DATA_W + 1;
  // The whole payload must still be available when the parity bit arrives.
  localparam int SHIFT_W = DATA_W;
`else
  localparam int SLOT_W  = DATA_W;
  // The last payload bit comes straight from din, so one bit less is stored.
  localparam int SHIFT_W = DATA_W - 1;
`endif
  localparam int CNT_W = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [1:0]            r_slot_cnt;
  logic [SHIFT_W-1:0]    r_shift;
  logic [4*DATA_W-1:0]   r_dout;
  logic [3:0]            r_dout_vld;
  logic                  r_locked;
  logic                  r_frame_err;

  logic                  w_frame_start;
  logic                  w_slot_last;
  logic [SHIFT_W-1:0]    w_shift_next;
  logic [SHIFT_W-1:0]    w_shift_first;
  logic [DATA_W-1:0]     w_payload;

  assign w_frame_start = (r_bit_cnt == '0) && (r_slot_cnt == 2'd0);
  assign w_slot_last   = (r_bit_cnt == LAST_BIT);
  // Truncating cast drops the oldest bit when the register is full.
  assign w_shift_next  = SHIFT_W'({r_shift, bus.din});
  assign w_shift_first = SHIFT_W'(bus.din);

`ifdef TDM_PARITY_EN
  logic [3:0] r_par_err;
  logic       w_par_bad;

  assign w_payload   = r_shift;
  assign w_par_bad   = (^r_shift) ^ bus.din;
  assign bus.par_err = r_par_err;
`else
  assign w_payload   = {r_shift, bus.din};
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_bit_cnt   <= '0;
      r_slot_cnt  <= 2'd0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_dout_vld  <= '0;
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef TDM_PARITY_EN
      r_par_err   <= '0;
`endif
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      r_dout_vld  <= '0;
      r_frame_err <= 1'b0;
`ifdef TDM_PARITY_EN
      r_par_err   <= '0;
`endif
      if (bus.din_vld) begin
        case (r_state)
          ST_HUNT: begin
            if (bus.sync) begin
              r_state    <= ST_RUN;
              r_locked   <= 1'b1;
              r_shift    <= w_shift_first;
              r_bit_cnt  <= CNT_W'(1);
              r_slot_cnt <= 2'd0;
            end
          end

          ST_RUN: begin
            if (w_frame_start && !bus.sync) begin
              // Expected frame start without a marker: lose lock.
              r_frame_err <= 1'b1;
              r_state     <= ST_HUNT;
              r_locked    <= 1'b0;
              r_bit_cnt   <= '0;
              r_slot_cnt  <= 2'd0;
            end else if (bus.sync && !w_frame_start) begin
              // Early or late marker: drop the partial slot and realign so
              // this bit is bit 0 of slot 0.
              r_frame_err <= 1'b1;
              r_shift     <= w_shift_first;
              r_bit_cnt   <= CNT_W'(1);
              r_slot_cnt  <= 2'd0;
            end else if (w_slot_last) begin
              r_dout[32'(r_slot_cnt) * DATA_W +: DATA_W] <= w_payload;
              r_dout_vld[r_slot_cnt] <= 1'b1;
`ifdef TDM_PARITY_EN
              r_par_err[r_slot_cnt]  <= w_par_bad;
`endif
              r_bit_cnt  <= '0;
              r_slot_cnt <= r_slot_cnt + 2'd1;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.dout_vld  = r_dout_vld;
  assign bus.locked    = r_locked;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

  localparam int DATA_W = 8;
`ifdef TDM_PARITY_EN
  localparam int SLOT_W = DATA_W + 1;
`else
  localparam int SLOT_W = DATA_W;
`endif

  typedef struct {
    int                slot;
    logic [DATA_W-1:0] data;
    logic              perr;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  tdm_demux_1to4_if #(.DATA_W(DATA_W)) bus ();

  tdm_demux_1to4 #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every dout_vld pulse must match the oldest expected slot.
  always @(negedge clk) begin
    if (!rst && (bus.dout_vld !== 4'b0000)) begin
      check("vld_onehot", 128'($countones(bus.dout_vld)), 128'd1);
      if (sb_q.size() == 0) begin
        check("vld_unexpected", 128'(bus.dout_vld), 128'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("vld_slot", 128'(bus.dout_vld), 128'(4'b0001 << e.slot));
        check("slot_data", 128'(bus.dout[e.slot*DATA_W +: DATA_W]), 128'(e.data));
`ifdef TDM_PARITY_EN
        check("par_err", 128'(bus.par_err), 128'(e.perr ? (4'b0001 << e.slot) : 4'b0000));
`endif
      end
    end
  end

  // One valid bit; checks the registered result one half cycle after the edge.
  task automatic send_bit(input logic b, input logic s, input logic exp_ferr,
                          input logic exp_locked, input logic [3:0] exp_vld);
    bus.din     = b;
    bus.sync    = s;
    bus.din_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("frame_err", 128'(bus.frame_err), 128'(exp_ferr));
    check("locked", 128'(bus.locked), 128'(exp_locked));
    check("dout_vld", 128'(bus.dout_vld), 128'(exp_vld));
    bus.din_vld = 1'b0;
    bus.sync    = 1'b0;
  endtask

  // A cycle with din_vld=0: pulses drop, lock is held.
  task automatic idle(input logic exp_locked);
    bus.din_vld = 1'b0;
    bus.din     = 1'b1;
    bus.sync    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_vld", 128'(bus.dout_vld), 128'd0);
    check("idle_ferr", 128'(bus.frame_err), 128'd0);
    check("idle_locked", 128'(bus.locked), 128'(exp_locked));
    bus.sync = 1'b0;
  endtask

  task automatic send_slot(input int k, input logic [DATA_W-1:0] data,
                           input logic first_sync, input logic first_ferr,
                           input logic bad_par, input logic gap);
    for (int i = 0; i < SLOT_W; i++) begin
      logic b;
      logic last;
      b    = (i < DATA_W) ? data[DATA_W-1-i] : ((^data) ^ bad_par);
      last = (i == SLOT_W - 1);
      if (last) begin
        exp_t e;
        e.slot = k;
        e.data = data;
        e.perr = bad_par;
        sb_q.push_back(e);
      end
      send_bit(b, first_sync && (i == 0), first_ferr && (i == 0), 1'b1,
               last ? (4'b0001 << k) : 4'b0000);
      if (gap) idle(1'b1);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                            input logic [DATA_W-1:0] b2, input logic [DATA_W-1:0] b3,
                            input logic first_ferr, input logic gap, input logic bad0);
    logic [DATA_W-1:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int k = 0; k < 4; k++)
      send_slot(k, bytes[k], k == 0, first_ferr && (k == 0), bad0 && (k == 0), gap);
  endtask

  // Leading bits of a slot that will never complete: no pulse expected.
  task automatic send_partial(input int nbits, input logic [DATA_W-1:0] data);
    for (int i = 0; i < nbits; i++)
      send_bit(data[DATA_W-1-i], 1'b0, 1'b0, 1'b1, 4'b0000);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.din     = 1'b0;
    bus.din_vld = 1'b0;
    bus.sync    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 128'(bus.dout), 128'd0);
    check("rst_vld", 128'(bus.dout_vld), 128'd0);
    check("rst_locked", 128'(bus.locked), 128'd0);
    check("rst_ferr", 128'(bus.frame_err), 128'd0);
    rst = 1'b0;

    // Hunting bits without sync are discarded
    send_bit(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // First frame, continuous stream
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("frame1_dout", 128'(bus.dout), 128'h01FF3CA5);

    // Second frame back-to-back, sync on bit 32
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    check("frame2_dout", 128'(bus.dout), 128'h44332211);

    // Missing sync at the expected frame start
    send_bit(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("unlock_dout", 128'(bus.dout), 128'h44332211);
    send_frame(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 1'b0, 1'b0);
    check("relock_dout", 128'(bus.dout), 128'h88776655);

    // Early sync at bit 5 of slot 1
    send_slot(0, 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0);
    send_partial(5, 8'hF0);
    check("early_pre_dout", 128'(bus.dout), 128'h8877669A);
    send_frame(8'hC3, 8'hD4, 8'hE5, 8'hF6, 1'b1, 1'b0, 1'b0);
    check("early_post_dout", 128'(bus.dout), 128'hF6E5D4C3);

    // din_vld toggling 1,0,1,0 through a frame
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    check("gap_dout", 128'(bus.dout), 128'h01FF3CA5);

    // Reset in the middle of slot 2
    send_slot(0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    send_slot(1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    send_partial(3, 8'h30);
    rst         = 1'b1;
    bus.din_vld = 1'b1;
    bus.sync    = 1'b1;
    bus.din     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_dout", 128'(bus.dout), 128'd0);
    check("midrst_vld", 128'(bus.dout_vld), 128'd0);
    check("midrst_locked", 128'(bus.locked), 128'd0);
    check("midrst_ferr", 128'(bus.frame_err), 128'd0);
    rst         = 1'b0;
    bus.din_vld = 1'b0;
    bus.sync    = 1'b0;
    send_frame(8'h0F, 8'h1E, 8'h2D, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("postrst_dout", 128'(bus.dout), 128'h3C2D1E0F);

`ifdef TDM_PARITY_EN
    // Bad parity on slot 0: payload still stored, par_err[0] pulses
    send_frame(8'hA5, 8'h5A, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("par_dout", 128'(bus.dout), 128'h3CC35AA5);
`endif

    repeat (3) idle(1'b1);
    check("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
